// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: sequences a job of up to INST_NUM instructions into a PE.
// Each instruction issues inst_data beats with incrementing operand addresses.
// PE results are collected into a small result buffer in arrival order.
module pe_seq_ctrl #(
  parameter int INST_NUM = 4,
  parameter int ADDR_W   = 16,
  parameter int RES_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        inst_cnt,
  input  logic              hold,
  output logic [1:0]        inst_addr,
  input  logic [7:0]        inst_data,
  output logic [ADDR_W-1:0] neuron_addr,
  output logic [ADDR_W-1:0] weight_addr,
  output logic              pe_vld,
  output logic [1:0]        pe_ctl,
  input  logic [RES_W-1:0]  pe_result,
  input  logic              pe_vld_o,
  output logic              res_wr_en,
  output logic [1:0]        res_wr_addr,
  output logic [RES_W-1:0]  res_wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            r_state;
  logic [1:0]        r_inst_addr;
  logic [2:0]        r_cnt;
  logic [7:0]        r_len;
  logic [7:0]        r_iter;
  logic [ADDR_W-1:0] r_naddr;
  logic [ADDR_W-1:0] r_waddr;
  logic [2:0]        r_exp;
  logic [2:0]        r_rcv;
  logic              r_err;

  state_t            w_state_nxt;
  logic [1:0]        w_inst_addr_nxt;
  logic [2:0]        w_cnt_nxt;
  logic [7:0]        w_len_nxt;
  logic [7:0]        w_iter_nxt;
  logic [ADDR_W-1:0] w_naddr_nxt;
  logic [ADDR_W-1:0] w_waddr_nxt;
  logic [2:0]        w_exp_nxt;
  logic [2:0]        w_rcv_nxt;
  logic              w_err_nxt;
  logic              w_pe_vld;
  logic [1:0]        w_pe_ctl;
  logic              w_res_acc;
  logic              w_res_bad;
  logic              w_last_inst;
  logic [2:0]        w_cnt_in;

  // Clamp an out-of-range instruction count so inst_addr never runs past the memory
  assign w_cnt_in    = (inst_cnt > 3'(INST_NUM)) ? 3'(INST_NUM) : inst_cnt;
  // Current instruction is the final one of the job
  assign w_last_inst = ({1'b0, r_inst_addr} == (r_cnt - 3'd1));

  // Next-state, datapath updates and beat/result outputs
  always_comb begin
    w_state_nxt     = r_state;
    w_inst_addr_nxt = r_inst_addr;
    w_cnt_nxt       = r_cnt;
    w_len_nxt       = r_len;
    w_iter_nxt      = r_iter;
    w_naddr_nxt     = r_naddr;
    w_waddr_nxt     = r_waddr;
    w_exp_nxt       = r_exp;
    w_rcv_nxt       = r_rcv;
    w_err_nxt       = r_err;
    w_pe_vld        = 1'b0;
    w_pe_ctl        = 2'b00;
    w_res_acc       = 1'b0;
    w_res_bad       = 1'b0;

    // A result is accepted only while a job is active and still owes results
    if (pe_vld_o) begin
      if (((r_state == S_LOAD) || (r_state == S_FEED) || (r_state == S_DRAIN)) &&
          (r_rcv < r_exp)) begin
        w_res_acc = 1'b1;
        w_rcv_nxt = r_rcv + 3'd1;
      end else begin
        w_res_bad = 1'b1;
      end
    end else begin
      w_res_acc = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_inst_addr_nxt = 2'd0;
          w_naddr_nxt     = '0;
          w_waddr_nxt     = '0;
          w_iter_nxt      = 8'd0;
          w_rcv_nxt       = 3'd0;
          w_exp_nxt       = 3'd0;
          w_err_nxt       = 1'b0;
          w_cnt_nxt       = w_cnt_in;
          w_state_nxt     = (w_cnt_in == 3'd0) ? S_DONE : S_LOAD;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LOAD: begin
        // Bubble cycle: inspect the instruction, skip empty ones
        if (inst_data == 8'd0) begin
          if (w_last_inst) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_inst_addr_nxt = r_inst_addr + 2'd1;
          end
        end else begin
          w_iter_nxt  = 8'd0;
          w_len_nxt   = inst_data;
          w_exp_nxt   = r_exp + 3'd1;
          w_state_nxt = S_FEED;
        end
      end
      S_FEED: begin
        if (hold) begin
          w_pe_vld = 1'b0;
        end else begin
          w_pe_vld    = 1'b1;
          w_pe_ctl[0] = (r_iter == 8'd0);
          w_pe_ctl[1] = (r_iter == (r_len - 8'd1));
          w_iter_nxt  = r_iter + 8'd1;
          w_naddr_nxt = r_naddr + ADDR_W'(1);
          w_waddr_nxt = r_waddr + ADDR_W'(1);
          if (r_iter == (r_len - 8'd1)) begin
            if (w_last_inst) begin
              w_state_nxt = S_DRAIN;
            end else begin
              w_inst_addr_nxt = r_inst_addr + 2'd1;
              w_state_nxt     = S_LOAD;
            end
          end else begin
            w_state_nxt = S_FEED;
          end
        end
      end
      S_DRAIN: begin
        // Count includes a result accepted in this very cycle
        if (w_rcv_nxt == r_exp) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // An unexpected result is flagged even in the cycle a new job is accepted
    if (w_res_bad) begin
      w_err_nxt = 1'b1;
    end else begin
      w_err_nxt = w_err_nxt;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_inst_addr <= 2'd0;
      r_cnt       <= 3'd0;
      r_len       <= 8'd0;
      r_iter      <= 8'd0;
      r_naddr     <= '0;
      r_waddr     <= '0;
      r_exp       <= 3'd0;
      r_rcv       <= 3'd0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_inst_addr <= w_inst_addr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_len       <= w_len_nxt;
      r_iter      <= w_iter_nxt;
      r_naddr     <= w_naddr_nxt;
      r_waddr     <= w_waddr_nxt;
      r_exp       <= w_exp_nxt;
      r_rcv       <= w_rcv_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign inst_addr   = r_inst_addr;
  assign neuron_addr = r_naddr;
  assign weight_addr = r_waddr;
  assign pe_vld      = w_pe_vld;
  assign pe_ctl      = w_pe_ctl;
  assign res_wr_en   = w_res_acc;
  assign res_wr_addr = w_res_acc ? r_rcv[1:0] : 2'd0;
  assign res_wr_data = w_res_acc ? pe_result : '0;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign err         = r_err;

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Testbench for pe_seq_ctrl: directed scenarios plus randomized jobs, each
// checked against a job-level model (beat list and result order).
module tb_pe_seq_ctrl;
  localparam int RES_W = 32;

  logic              clk = 1'b0;
  logic              rst, start, hold, pe_vld_o;
  logic [2:0]        inst_cnt;
  logic [1:0]        inst_addr;
  logic [7:0]        inst_data;
  logic [15:0]       neuron_addr, weight_addr;
  logic              pe_vld;
  logic [1:0]        pe_ctl;
  logic [RES_W-1:0]  pe_result;
  logic              res_wr_en;
  logic [1:0]        res_wr_addr;
  logic [RES_W-1:0]  res_wr_data;
  logic              busy, done, err;

  logic [7:0] mem [4];
  int n_chk = 0;
  int n_err = 0;

  assign inst_data = mem[inst_addr];

  pe_seq_ctrl #(.INST_NUM(4), .ADDR_W(16), .RES_W(RES_W)) dut (
    .clk(clk), .rst(rst), .start(start), .inst_cnt(inst_cnt), .hold(hold),
    .inst_addr(inst_addr), .inst_data(inst_data),
    .neuron_addr(neuron_addr), .weight_addr(weight_addr),
    .pe_vld(pe_vld), .pe_ctl(pe_ctl), .pe_result(pe_result), .pe_vld_o(pe_vld_o),
    .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " inst_addr"}, 64'(inst_addr), 64'd0);
    chk({nm, " neuron_addr"}, 64'(neuron_addr), 64'd0);
    chk({nm, " weight_addr"}, 64'(weight_addr), 64'd0);
    chk({nm, " pe_vld"}, 64'(pe_vld), 64'd0);
    chk({nm, " pe_ctl"}, 64'(pe_ctl), 64'd0);
    chk({nm, " res_wr_en"}, 64'(res_wr_en), 64'd0);
    chk({nm, " res_wr_addr"}, 64'(res_wr_addr), 64'd0);
    chk({nm, " res_wr_data"}, 64'(res_wr_data), 64'd0);
    chk({nm, " busy"}, 64'(busy), 64'd0);
    chk({nm, " done"}, 64'(done), 64'd0);
    chk({nm, " err"}, 64'(err), 64'd0);
  endtask

  // Run one job from IDLE. hmode: 0 no hold, 1 random hold and stray starts,
  // 2 hold three cycles before beat 7. lat: PE result latency after last beat.
  task automatic run_job(input int cnt, input int lat, input int hmode, input string nm);
    logic [1:0]       ectl [$];
    int               rq_t [$];
    logic [RES_W-1:0] rq_d [$];
    int nb, nres, bi, wr_idx, cyc, hc, lb_cyc, lr_cyc;
    bit seen_done;
    nres = 0;
    for (int i = 0; i < cnt; i++) begin
      if (mem[i] != 8'd0) nres++;
      for (int k = 0; k < int'(mem[i]); k++)
        ectl.push_back({(k == int'(mem[i]) - 1), (k == 0)});
    end
    nb = ectl.size();
    start = 1'b1; inst_cnt = 3'(cnt); hold = 1'b0; pe_vld_o = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    bi = 0; wr_idx = 0; cyc = 1; hc = 0; lb_cyc = -1; lr_cyc = -1; seen_done = 1'b0;
    while (!seen_done && cyc < 3000) begin
      hold = 1'b0;
      if (hmode == 1) hold = ($urandom_range(0, 3) == 0);
      else if (hmode == 2 && bi == 7 && hc < 3) begin hold = 1'b1; hc++; end
      if (hmode == 1 && $urandom_range(0, 9) == 0) begin
        start = 1'b1; inst_cnt = 3'($urandom_range(0, 4));
      end else begin
        start = 1'b0;
      end
      pe_vld_o = 1'b0;
      if (rq_t.size() > 0 && rq_t[0] == cyc) begin
        pe_vld_o = 1'b1;
        pe_result = rq_d.pop_front();
        void'(rq_t.pop_front());
      end
      #1;
      chk({nm, " neuron_addr"}, 64'(neuron_addr), 64'(bi % 65536));
      chk({nm, " weight_addr"}, 64'(weight_addr), 64'(bi % 65536));
      chk({nm, " busy"}, 64'(busy), 64'd1);
      chk({nm, " err"}, 64'(err), 64'd0);
      if (hold) chk({nm, " pe_vld under hold"}, 64'(pe_vld), 64'd0);
      if (pe_vld) begin
        if (bi < nb) chk({nm, " pe_ctl"}, 64'(pe_ctl), 64'(ectl[bi]));
        else chk({nm, " beat count overrun"}, 64'(bi + 1), 64'(nb));
        if (bi == 0 && hmode == 0 && mem[0] != 8'd0)
          chk({nm, " first beat latency"}, 64'(cyc), 64'd2);
        if (pe_ctl[1]) begin
          lb_cyc = cyc;
          if (lat == 0) begin
            pe_vld_o = 1'b1;
            pe_result = $urandom;
            #1;
          end else begin
            rq_t.push_back(cyc + lat);
            rq_d.push_back($urandom);
          end
        end
        bi++;
      end else begin
        chk({nm, " pe_ctl idle"}, 64'(pe_ctl), 64'd0);
      end
      chk({nm, " res_wr_en"}, 64'(res_wr_en), 64'(pe_vld_o));
      if (pe_vld_o) begin
        chk({nm, " res_wr_addr"}, 64'(res_wr_addr), 64'(wr_idx));
        chk({nm, " res_wr_data"}, 64'(res_wr_data), 64'(pe_result));
        wr_idx++;
        lr_cyc = cyc;
      end
      if (done) begin
        seen_done = 1'b1;
        start = 1'b0;
        chk({nm, " total beats"}, 64'(bi), 64'(nb));
        chk({nm, " total results"}, 64'(wr_idx), 64'(nres));
        if (cnt == 0) chk({nm, " done latency"}, 64'(cyc), 64'd1);
        else if (mem[cnt-1] != 8'd0)
          chk({nm, " done timing"}, 64'(cyc),
              64'(((lb_cyc + 1) > lr_cyc ? (lb_cyc + 1) : lr_cyc) + 1));
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({nm, " done seen before timeout"}, 64'(seen_done), 64'd1);
    hold = 1'b0; pe_vld_o = 1'b0; start = 1'b0;
    #1;
    chk({nm, " done one cycle"}, 64'(done), 64'd0);
    chk({nm, " busy after done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; pe_vld_o = 1'b0;
    inst_cnt = 3'd0; pe_result = '0;
    mem[0] = 8'd0; mem[1] = 8'd0; mem[2] = 8'd0; mem[3] = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Four full instructions of 32 beats
    mem[0] = 8'h20; mem[1] = 8'h20; mem[2] = 8'h20; mem[3] = 8'h20;
    run_job(4, 3, 0, "four_x32");

    // Single-beat instruction sets both ctl bits
    mem[0] = 8'd1; mem[1] = 8'd3;
    run_job(2, 1, 0, "one_three");

    // Middle instruction skipped
    mem[0] = 8'd5; mem[1] = 8'd0; mem[2] = 8'd5;
    run_job(3, 2, 0, "skip_mid");

    // Last instruction skipped goes straight to drain
    mem[0] = 8'd3; mem[1] = 8'd0; mem[2] = 8'd0;
    run_job(3, 4, 0, "skip_last");

    // Hold on beat 7 of a 16-beat instruction, result in last-beat cycle
    mem[0] = 8'd16;
    run_job(1, 0, 2, "hold_beat7");

    // Reset in the middle of feeding, then replay
    mem[0] = 8'd16;
    start = 1'b1; inst_cnt = 3'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("midrst beat10 vld", 64'(pe_vld), 64'd1);
    chk("midrst beat10 addr", 64'(neuron_addr), 64'd10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_all_zero("midrst");
    run_job(1, 2, 0, "replay");

    // Stray result in IDLE flags err without writing; empty job clears it
    pe_vld_o = 1'b1; pe_result = 32'hDEADBEEF;
    #1;
    chk("idle res_wr_en", 64'(res_wr_en), 64'd0);
    chk("idle res_wr_data", 64'(res_wr_data), 64'd0);
    @(posedge clk); #1;
    pe_vld_o = 1'b0;
    chk("idle err set", 64'(err), 64'd1);
    @(posedge clk); #1;
    chk("idle err sticky", 64'(err), 64'd1);
    run_job(0, 1, 0, "empty_job");

    // Randomized jobs
    for (int j = 0; j < 30; j++) begin
      int c, v;
      c = $urandom_range(0, 4);
      for (int i = 0; i < 4; i++) begin
        v = $urandom_range(0, 5);
        mem[i] = (v == 0) ? 8'd0 : (v == 1) ? 8'd1 : 8'($urandom_range(2, 12));
      end
      run_job(c, $urandom_range(0, 4), (j % 3 == 0) ? 0 : 1, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
